// File: rtl/wqe_fetch_ctrl_if.sv
// rtl/wqe_fetch_ctrl_if.sv - DMA read request / response bundle between WQE fetch and host DMA
//
// Purpose: carries the WQE read request handshake and the in-order response beats.
// Signals:
//   dma_rd_val    master->slave  read request valid
//   dma_rd_rdy    slave->master  read request accepted when val & rdy
//   dma_rd_addr   master->slave  host address of the 64B WQE
//   dma_rd_qpn    master->slave  QP the read belongs to
//   dma_rsp_val   slave->master  response beat valid (returns in request order)
//   dma_rsp_data  slave->master  WQE contents
interface wqe_fetch_ctrl_if #(
  parameter int ADDR_WIDTH   = 64,
  parameter int QP_PTR_WIDTH = 4,
  parameter int WQE_WIDTH    = 512
) ();
  logic                    dma_rd_val;
  logic                    dma_rd_rdy;
  logic [ADDR_WIDTH-1:0]   dma_rd_addr;
  logic [QP_PTR_WIDTH-1:0] dma_rd_qpn;
  logic                    dma_rsp_val;
  logic [WQE_WIDTH-1:0]    dma_rsp_data;

  modport master (
    output dma_rd_val, dma_rd_addr, dma_rd_qpn,
    input  dma_rd_rdy, dma_rsp_val, dma_rsp_data
  );

  modport slave (
    input  dma_rd_val, dma_rd_addr, dma_rd_qpn,
    output dma_rd_rdy, dma_rsp_val, dma_rsp_data
  );
endinterface

// File: rtl/wqe_fetch_ctrl.sv
// rtl/wqe_fetch_ctrl.sv - per-QP send-ring tracking, round-robin WQE DMA fetch into the WQE cache
//
// Purpose: keeps producer/consumer indices per QP from doorbells, picks the next QP with pending
// WQEs round-robin, issues one 64B DMA read per WQE and forwards returned WQEs to the cache.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_cfg_wen/qpn/base         program ring base of a QP (marks it valid, clears pi/ci)
//   i_db_val/qpn/pi            doorbell: new producer index for a QP
//   o_db_err                   1-cycle pulse, doorbell rejected
//   dma (master)               DMA read request / response bundle
//   o_rsp_err                  1-cycle pulse, response arrived with no read outstanding
//   i_wqe_cache_alfull         cache almost full, blocks new requests only
//   o_wqe_cache_wr, o_wqe      registered WQE write into the cache
//   o_busy                     reads outstanding or any valid QP has pi != ci
module wqe_fetch_ctrl #(
  parameter int WQE_WIDTH       = 512,
  parameter int QP_PTR_WIDTH    = 4,
  parameter int IDX_WIDTH       = 16,
  parameter int RING_DEPTH_LOG2 = 8,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_wen,
  input  logic [QP_PTR_WIDTH-1:0] i_cfg_qpn,
  input  logic [ADDR_WIDTH-1:0]   i_cfg_base,
  input  logic                    i_db_val,
  input  logic [QP_PTR_WIDTH-1:0] i_db_qpn,
  input  logic [IDX_WIDTH-1:0]    i_db_pi,
  output logic                    o_db_err,
  wqe_fetch_ctrl_if.master        dma,
  output logic                    o_rsp_err,
  input  logic                    i_wqe_cache_alfull,
  output logic                    o_wqe_cache_wr,
  output logic [WQE_WIDTH-1:0]    o_wqe,
  output logic                    o_busy
);

  localparam int QP_NUM = 1 << QP_PTR_WIDTH;
  // Largest legal pi - ci distance: a completely full ring.
  localparam logic [IDX_WIDTH:0] RING_ENTRIES = (IDX_WIDTH+1)'(1) << RING_DEPTH_LOG2;
  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t                  state_q, state_d;
  logic [QP_NUM-1:0]       valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   base_q [QP_NUM];
  logic [ADDR_WIDTH-1:0]   base_d [QP_NUM];
  logic [IDX_WIDTH-1:0]    pi_q   [QP_NUM];
  logic [IDX_WIDTH-1:0]    pi_d   [QP_NUM];
  logic [IDX_WIDTH-1:0]    ci_q   [QP_NUM];
  logic [IDX_WIDTH-1:0]    ci_d   [QP_NUM];
  logic [QP_PTR_WIDTH-1:0] rr_q, rr_d;
  logic [2:0]              outstanding_q, outstanding_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [QP_PTR_WIDTH-1:0] req_qpn_q, req_qpn_d;
  logic                    db_err_q, db_err_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    wqe_wr_q, wqe_wr_d;
  logic [WQE_WIDTH-1:0]    wqe_q, wqe_d;

  logic [IDX_WIDTH-1:0]       db_dist;
  logic                       db_ok;
  logic [QP_NUM-1:0]          pending;
  logic                       grant_found;
  logic [QP_PTR_WIDTH-1:0]    grant_qpn;
  logic [QP_PTR_WIDTH-1:0]    arb_idx;
  logic [IDX_WIDTH-1:0]       grant_ci;
  logic [ADDR_WIDTH-1:0]      grant_addr;
  logic                       rd_accept;
  logic                       rsp_ok;

  // Doorbell is legal only if the new pi is at most one full ring ahead of ci (mod index width).
  always_comb begin
    db_dist = i_db_pi - ci_q[i_db_qpn];
    db_ok   = valid_q[i_db_qpn] && ({1'b0, db_dist} <= RING_ENTRIES);
  end

  always_comb begin
    for (int q = 0; q < QP_NUM; q++) begin
      pending[q] = valid_q[q] && (pi_q[q] != ci_q[q]);
    end
  end

  // Round-robin: first pending QP at or after rr_q; the index adder wraps modulo QP_NUM.
  always_comb begin
    grant_found = 1'b0;
    grant_qpn   = '0;
    arb_idx     = '0;
    for (int i = 0; i < QP_NUM; i++) begin
      arb_idx = rr_q + QP_PTR_WIDTH'(i);
      if (!grant_found && pending[arb_idx]) begin
        grant_found = 1'b1;
        grant_qpn   = arb_idx;
      end
    end
  end

  // Slot offset comes from the low ci bits only, so ring wrap needs no extra logic.
  always_comb begin
    grant_ci   = ci_q[grant_qpn];
    grant_addr = base_q[grant_qpn]
               + ADDR_WIDTH'({grant_ci[RING_DEPTH_LOG2-1:0], 6'b0});
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_qpn_d  = req_qpn_q;
    rr_d       = rr_q;
    rd_accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found && !i_wqe_cache_alfull && (outstanding_q < MAX_OUT)) begin
          req_addr_d = grant_addr;
          req_qpn_d  = grant_qpn;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dma.dma_rd_rdy) begin
          rd_accept = 1'b1;
          rr_d      = req_qpn_q + QP_PTR_WIDTH'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-QP ring state. Order matters: doorbell and ci increment both apply, cfg overrides both.
  always_comb begin
    for (int q = 0; q < QP_NUM; q++) begin
      valid_d[q] = valid_q[q];
      base_d[q]  = base_q[q];
      pi_d[q]    = pi_q[q];
      ci_d[q]    = ci_q[q];
      if (i_db_val && db_ok && (i_db_qpn == QP_PTR_WIDTH'(q))) begin
        pi_d[q] = i_db_pi;
      end
      if (rd_accept && (req_qpn_q == QP_PTR_WIDTH'(q))) begin
        ci_d[q] = ci_q[q] + IDX_WIDTH'(1);
      end
      if (i_cfg_wen && (i_cfg_qpn == QP_PTR_WIDTH'(q))) begin
        valid_d[q] = 1'b1;
        base_d[q]  = i_cfg_base;
        pi_d[q]    = '0;
        ci_d[q]    = '0;
      end
    end
  end

  // A response with nothing in flight is an error and is dropped rather than written.
  always_comb begin
    rsp_ok    = dma.dma_rsp_val && (outstanding_q != 3'd0);
    rsp_err_d = dma.dma_rsp_val && (outstanding_q == 3'd0);
    wqe_wr_d  = rsp_ok;
    wqe_d     = rsp_ok ? dma.dma_rsp_data : wqe_q;
    db_err_d  = i_db_val && !db_ok;
    case ({rd_accept, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      for (int q = 0; q < QP_NUM; q++) begin
        base_q[q] <= '0;
        pi_q[q]   <= '0;
        ci_q[q]   <= '0;
      end
      rr_q          <= '0;
      outstanding_q <= '0;
      req_addr_q    <= '0;
      req_qpn_q     <= '0;
      db_err_q      <= 1'b0;
      rsp_err_q     <= 1'b0;
      wqe_wr_q      <= 1'b0;
      wqe_q         <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      base_q        <= base_d;
      pi_q          <= pi_d;
      ci_q          <= ci_d;
      rr_q          <= rr_d;
      outstanding_q <= outstanding_d;
      req_addr_q    <= req_addr_d;
      req_qpn_q     <= req_qpn_d;
      db_err_q      <= db_err_d;
      rsp_err_q     <= rsp_err_d;
      wqe_wr_q      <= wqe_wr_d;
      wqe_q         <= wqe_d;
    end
  end

  assign dma.dma_rd_val  = (state_q == ST_REQ);
  assign dma.dma_rd_addr = req_addr_q;
  assign dma.dma_rd_qpn  = req_qpn_q;
  assign o_db_err        = db_err_q;
  assign o_rsp_err       = rsp_err_q;
  assign o_wqe_cache_wr  = wqe_wr_q;
  assign o_wqe           = wqe_q;
  assign o_busy          = (outstanding_q != 3'd0) || (|pending);

endmodule
